// File: rtl/wb_round_robin_arbiter_if.sv
// rtl/wb_round_robin_arbiter_if.sv - Wishbone bundle between an array of masters, the arbiter and one slave
interface wb_round_robin_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int aw          = 32,
   parameter int dw          = 32
);
   logic [NUM_MASTERS*aw-1:0] wbm_adr_i;
   logic [NUM_MASTERS*dw-1:0] wbm_dat_i;
   logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
   logic [NUM_MASTERS-1:0]    wbm_we_i;
   logic [NUM_MASTERS-1:0]    wbm_cyc_i;
   logic [NUM_MASTERS-1:0]    wbm_stb_i;
   logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
   logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
   logic [dw-1:0]             wbm_sdt_o;
   logic [NUM_MASTERS-1:0]    wbm_ack_o;
   logic [NUM_MASTERS-1:0]    wbm_err_o;
   logic [NUM_MASTERS-1:0]    wbm_rty_o;

   logic [aw-1:0]             wbs_adr_o;
   logic [dw-1:0]             wbs_dat_o;
   logic [3:0]                wbs_sel_o;
   logic                      wbs_we_o;
   logic                      wbs_cyc_o;
   logic                      wbs_stb_o;
   logic [2:0]                wbs_cti_o;
   logic [1:0]                wbs_bte_o;
   logic [dw-1:0]             wbs_sdt_i;
   logic                      wbs_ack_i;
   logic                      wbs_err_i;
   logic                      wbs_rty_i;

   // Arbiter-side view: slave to the master array, master to the shared slave.
   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      output wbm_sdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
      input  wbs_sdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );

   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      input  wbm_sdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
      output wbs_sdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );
endinterface

// File: rtl/wb_round_robin_arbiter.sv
// rtl/wb_round_robin_arbiter.sv - round-robin Wishbone arbiter granting whole CYC frames, with stall watchdog
module wb_round_robin_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int aw          = 32,
   parameter int dw          = 32,
   parameter int TIMEOUT     = 256
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   wb_round_robin_arbiter_if.slave bus,
   output logic [NUM_MASTERS-1:0] grant_o
);
   localparam int LW = $clog2(NUM_MASTERS);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [LW-1:0]          last_q, last_d;
   logic [LW-1:0]          pick;
   logic                   pick_valid;
   logic                   stb_raw;
   logic                   resp;
   logic                   fire;

   // First requester after the previous grantee; the previous grantee itself is reached last.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         if (bus.wbm_cyc_i[(int'(last_q) + i) % NUM_MASTERS]) begin
            pick       = LW'((int'(last_q) + i) % NUM_MASTERS);
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d       = OWNED;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               last_d        = pick;
            end
         end
         OWNED: begin
            // The owner keeps the bus for its whole CYC frame; others are ignored.
            if (!bus.wbm_cyc_i[last_q]) begin
               if (pick_valid) begin
                  grant_d       = '0;
                  grant_d[pick] = 1'b1;
                  last_d        = pick;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      bus.wbs_adr_o = '0;
      bus.wbs_dat_o = '0;
      bus.wbs_sel_o = '0;
      bus.wbs_we_o  = 1'b0;
      bus.wbs_cyc_o = 1'b0;
      bus.wbs_cti_o = '0;
      bus.wbs_bte_o = '0;
      stb_raw       = 1'b0;
      if (state_q == OWNED) begin
         bus.wbs_adr_o = bus.wbm_adr_i[int'(last_q)*aw +: aw];
         bus.wbs_dat_o = bus.wbm_dat_i[int'(last_q)*dw +: dw];
         bus.wbs_sel_o = bus.wbm_sel_i[int'(last_q)*4 +: 4];
         bus.wbs_we_o  = bus.wbm_we_i[last_q];
         bus.wbs_cyc_o = bus.wbm_cyc_i[last_q];
         bus.wbs_cti_o = bus.wbm_cti_i[int'(last_q)*3 +: 3];
         bus.wbs_bte_o = bus.wbm_bte_i[int'(last_q)*2 +: 2];
         stb_raw       = bus.wbm_stb_i[last_q];
      end
   end

   assign resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

   generate
      if (TIMEOUT > 0) begin : g_wdog
         logic [CW-1:0] cnt_q;

         // A real slave response in the firing cycle takes precedence over the timeout.
         assign fire = stb_raw && !resp && (cnt_q == CW'(TIMEOUT - 1));

         always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || resp || !stb_raw || fire || (grant_d != grant_q)) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end else begin : g_no_wdog
         assign fire = 1'b0;
      end
   endgenerate

   assign bus.wbs_stb_o = stb_raw & ~fire;

   assign bus.wbm_sdt_o = bus.wbs_sdt_i;
   assign bus.wbm_ack_o = grant_q & {NUM_MASTERS{bus.wbs_ack_i}};
   assign bus.wbm_err_o = grant_q & {NUM_MASTERS{bus.wbs_err_i | fire}};
   assign bus.wbm_rty_o = grant_q & {NUM_MASTERS{bus.wbs_rty_i}};
   assign grant_o       = grant_q;
endmodule

// File: tb/tb_wb_round_robin_arbiter.sv
// tb/tb_wb_round_robin_arbiter.sv - self-checking bench for wb_round_robin_arbiter
module tb_wb_round_robin_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic [1:0] grant_a;
   logic [2:0] grant_b;

   wb_round_robin_arbiter_if #(.NUM_MASTERS(2), .aw(32), .dw(32)) ia ();
   wb_round_robin_arbiter_if #(.NUM_MASTERS(3), .aw(32), .dw(32)) ib ();

   wb_round_robin_arbiter #(.NUM_MASTERS(2), .aw(32), .dw(32), .TIMEOUT(16)) u_dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst_a), .bus(ia), .grant_o(grant_a));
   wb_round_robin_arbiter #(.NUM_MASTERS(3), .aw(32), .dw(32), .TIMEOUT(0)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst_b), .bus(ib), .grant_o(grant_b));

   // Registered-ack memory slave for A; manual ack path for cycle-exact vectors.
   logic        auto_a, man_ack_a, ack_q_a;
   logic [31:0] mem_a [0:255];
   always @(posedge clk) begin
      if (rst_a) ack_q_a <= 1'b0;
      else       ack_q_a <= ia.wbs_cyc_o & ia.wbs_stb_o & ~ack_q_a;
      if (ack_q_a & ia.wbs_cyc_o & ia.wbs_stb_o & ia.wbs_we_o)
         mem_a[ia.wbs_adr_o[9:2]] <= ia.wbs_dat_o;
   end
   assign ia.wbs_ack_i = auto_a ? ack_q_a : man_ack_a;
   assign ia.wbs_err_i = 1'b0;
   assign ia.wbs_rty_i = 1'b0;
   assign ia.wbs_sdt_i = mem_a[ia.wbs_adr_o[9:2]];

   logic en_b, ack_q_b;
   always @(posedge clk) begin
      if (rst_b) ack_q_b <= 1'b0;
      else       ack_q_b <= ib.wbs_cyc_o & ib.wbs_stb_o & ~ack_q_b;
   end
   assign ib.wbs_ack_i = en_b & ack_q_b;
   assign ib.wbs_err_i = 1'b0;
   assign ib.wbs_rty_i = 1'b0;
   assign ib.wbs_sdt_i = 32'h0;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic [1:0] cyc;
      logic       ack;
      logic [1:0] exp_grant;
      logic       exp_cyc;
      logic       exp_stb;
      logic [1:0] exp_ack;
   } vec_t;
   vec_t tbl [13];

   logic [31:0] exp_q [$];
   int          ord_q [$];

   task automatic a_single(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rd, output int lat, output logic [1:0] g1, output int other);
      rd = '0; lat = -1; g1 = '0; other = 0;
      @(posedge clk); #1;
      ia.wbm_cyc_i[m] = 1'b1;
      ia.wbm_stb_i[m] = 1'b1;
      ia.wbm_we_i[m]  = we;
      ia.wbm_adr_i[m*32 +: 32] = adr;
      ia.wbm_dat_i[m*32 +: 32] = dat;
      ia.wbm_sel_i[m*4 +: 4]   = 4'hf;
      ia.wbm_cti_i[m*3 +: 3]   = 3'b000;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (t == 1) g1 = grant_a;
         if (ia.wbm_ack_o[1-m]) other++;
         if (ia.wbm_ack_o[m]) begin
            rd = ia.wbm_sdt_o;
            lat = t;
            break;
         end
      end
      @(posedge clk); #1;
      ia.wbm_cyc_i[m] = 1'b0;
      ia.wbm_stb_i[m] = 1'b0;
      ia.wbm_we_i[m]  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          lat, other, beats, ack0, gbad, got, errs, err_at;
      logic [1:0]  g1;
      logic        found;
      logic [2:0]  drop;
      int          cnt [3];
      logic        errs_v [41];
      logic        stbs_v [41];

      //             cyc    ack   grant  cyc   stb   ack
      tbl[0]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
      tbl[1]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
      tbl[2]  = '{2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
      tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
      tbl[4]  = '{2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};
      tbl[5]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
      tbl[6]  = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
      tbl[7]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
      tbl[8]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
      tbl[9]  = '{2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00};
      tbl[10] = '{2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
      tbl[11] = '{2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10};
      tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};

      rst_a = 1'b1; rst_b = 1'b1;
      auto_a = 1'b0; man_ack_a = 1'b0; en_b = 1'b1;
      ia.wbm_adr_i = '0; ia.wbm_dat_i = '0; ia.wbm_sel_i = '0; ia.wbm_we_i = '0;
      ia.wbm_stb_i = '0; ia.wbm_cti_i = '0; ia.wbm_bte_i = '0;
      ia.wbm_cyc_i = 2'b11;
      ib.wbm_adr_i = '0; ib.wbm_dat_i = '0; ib.wbm_sel_i = '0; ib.wbm_we_i = '0;
      ib.wbm_cyc_i = '0; ib.wbm_stb_i = '0; ib.wbm_cti_i = '0; ib.wbm_bte_i = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {grant_a, ia.wbs_cyc_o, ia.wbs_stb_o, ia.wbm_ack_o, ia.wbm_err_o, ia.wbm_rty_o, grant_b},
          {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000});
      ia.wbm_cyc_i = 2'b00;
      rst_a = 1'b0; rst_b = 1'b0;

      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         ia.wbm_cyc_i = tbl[i].cyc;
         ia.wbm_stb_i = tbl[i].cyc;
         man_ack_a    = tbl[i].ack;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {grant_a, ia.wbs_cyc_o, ia.wbs_stb_o, ia.wbm_ack_o, ia.wbm_err_o},
             {tbl[i].exp_grant, tbl[i].exp_cyc, tbl[i].exp_stb, tbl[i].exp_ack, 2'b00});
      end
      @(posedge clk); #1;
      ia.wbm_cyc_i = 2'b00; ia.wbm_stb_i = 2'b00; man_ack_a = 1'b0;
      auto_a = 1'b1;

      // single master write then read-back
      a_single(0, 1'b1, 32'h100, 32'hDEADBEEF, rd, lat, g1, other);
      chk("wr_grant_t1", g1, 2'b01);
      chk("wr_ack_latency", lat, 2);
      chk("wr_other_ack", other, 0);
      exp_q.push_back(32'hDEADBEEF);
      a_single(0, 1'b0, 32'h100, 32'h0, rd, lat, g1, other);
      chk("rd_data", rd, exp_q.pop_front());
      chk("rd_other_ack", other, 0);

      // burst lock: master 1 bursts while master 0 waits
      @(posedge clk); #1;
      ia.wbm_cyc_i[1] = 1'b1; ia.wbm_stb_i[1] = 1'b1; ia.wbm_we_i[1] = 1'b1;
      ia.wbm_adr_i[63:32] = 32'h200; ia.wbm_dat_i[63:32] = 32'hB000_0000;
      ia.wbm_sel_i[7:4] = 4'hf; ia.wbm_cti_i[5:3] = 3'b010;
      @(posedge clk); #1;
      ia.wbm_cyc_i[0] = 1'b1; ia.wbm_stb_i[0] = 1'b1; ia.wbm_we_i[0] = 1'b0;
      ia.wbm_adr_i[31:0] = 32'h200;
      exp_q.push_back(32'hB000_0000);
      beats = 0; ack0 = 0; gbad = 0;
      for (int t = 0; t < 100 && beats < 8; t++) begin
         @(negedge clk);
         if (ia.wbm_ack_o[0]) ack0++;
         if (grant_a != 2'b10) gbad++;
         if (ia.wbm_ack_o[1]) begin
            beats++;
            @(posedge clk); #1;
            if (beats < 8) begin
               ia.wbm_adr_i[63:32] = ia.wbm_adr_i[63:32] + 32'd4;
               ia.wbm_dat_i[63:32] = 32'hB000_0000 + 32'(beats);
               ia.wbm_cti_i[5:3]   = (beats == 7) ? 3'b111 : 3'b010;
            end else begin
               ia.wbm_cyc_i[1] = 1'b0; ia.wbm_stb_i[1] = 1'b0; ia.wbm_we_i[1] = 1'b0;
               ia.wbm_cti_i[5:3] = 3'b000;
            end
         end
      end
      chk("burst_beats", beats, 8);
      chk("burst_m0_acks", ack0, 0);
      chk("burst_grant_held", gbad, 0);
      @(negedge clk);
      chk("burst_drop_cycle_grant", grant_a, 2'b10);
      @(negedge clk);
      chk("m0_after_burst_grant", grant_a, 2'b01);
      found = 1'b0; rd = '0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (ia.wbm_ack_o[0]) begin rd = ia.wbm_sdt_o; found = 1'b1; break; end
      end
      chk("burst_rd_first", {found, rd}, {1'b1, exp_q.pop_front()});
      @(posedge clk); #1;
      ia.wbm_cyc_i[0] = 1'b0; ia.wbm_stb_i[0] = 1'b0;
      exp_q.push_back(32'hB000_0007);
      a_single(0, 1'b0, 32'h21C, 32'h0, rd, lat, g1, other);
      chk("burst_rd_last", rd, exp_q.pop_front());

      // watchdog with no slave response
      auto_a = 1'b0; man_ack_a = 1'b0;
      @(posedge clk); #1;
      ia.wbm_cyc_i[0] = 1'b1; ia.wbm_stb_i[0] = 1'b1; ia.wbm_adr_i[31:0] = 32'h300;
      err_at = -1; errs = 0;
      for (int t = 0; t < 41; t++) begin
         @(negedge clk);
         errs_v[t] = ia.wbm_err_o[0];
         stbs_v[t] = ia.wbs_stb_o;
         if (ia.wbm_err_o != 2'b00) errs++;
         if (ia.wbm_err_o[0] && err_at < 0) err_at = t;
      end
      chk("wdog_fire_cycle", err_at, 16);
      chk("wdog_fire_stb_masked", {errs_v[16], stbs_v[16]}, 2'b10);
      chk("wdog_one_cycle", {errs_v[17], stbs_v[17]}, 2'b01);
      chk("wdog_err_count", errs, 2);
      chk("wdog_grant_held", grant_a, 2'b01);
      @(posedge clk); #1;
      ia.wbm_cyc_i[0] = 1'b0; ia.wbm_stb_i[0] = 1'b0;
      auto_a = 1'b1;

      // reset during beat 3 of a burst
      @(posedge clk); #1;
      ia.wbm_cyc_i[1] = 1'b1; ia.wbm_stb_i[1] = 1'b1; ia.wbm_we_i[1] = 1'b1;
      ia.wbm_adr_i[63:32] = 32'h240; ia.wbm_cti_i[5:3] = 3'b010;
      beats = 0;
      for (int t = 0; t < 60 && beats < 2; t++) begin
         @(negedge clk);
         if (ia.wbm_ack_o[1]) begin
            beats++;
            @(posedge clk); #1;
            ia.wbm_adr_i[63:32] = ia.wbm_adr_i[63:32] + 32'd4;
         end
      end
      chk("rst_burst_beats", beats, 2);
      rst_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_burst", {grant_a, ia.wbs_cyc_o, ia.wbs_stb_o}, {2'b00, 1'b0, 1'b0});
      rst_a = 1'b0;
      @(negedge clk);
      chk("rst_resume_grant", {grant_a, ia.wbs_cyc_o}, {2'b10, 1'b1});
      @(posedge clk); #1;
      ia.wbm_cyc_i[1] = 1'b0; ia.wbm_stb_i[1] = 1'b0; ia.wbm_we_i[1] = 1'b0;

      // fairness with three continuously requesting masters
      for (int n = 0; n < 30; n++) ord_q.push_back(n % 3);
      drop = 3'b000; got = 0;
      for (int m = 0; m < 3; m++) cnt[m] = 0;
      for (int t = 0; t < 300 && got < 30; t++) begin
         @(posedge clk); #1;
         ib.wbm_cyc_i = ~drop;
         ib.wbm_stb_i = ~drop;
         @(negedge clk);
         drop = ib.wbm_ack_o;
         for (int m = 0; m < 3; m++) begin
            if (ib.wbm_ack_o[m]) begin
               got++;
               cnt[m]++;
               chk($sformatf("fair_order%0d", got), m, ord_q.pop_front());
            end
         end
      end
      chk("fair_total", got, 30);
      for (int m = 0; m < 3; m++) chk($sformatf("fair_count_m%0d", m), cnt[m], 10);
      @(posedge clk); #1;
      ib.wbm_cyc_i = '0; ib.wbm_stb_i = '0;

      // TIMEOUT = 0: a stalled access waits indefinitely
      en_b = 1'b0;
      @(posedge clk); #1;
      ib.wbm_cyc_i[0] = 1'b1; ib.wbm_stb_i[0] = 1'b1;
      errs = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (ib.wbm_err_o != 3'b000) errs++;
      end
      chk("nowdog_no_err", errs, 0);
      chk("nowdog_still_waiting", {grant_b, ib.wbs_stb_o}, {3'b001, 1'b1});
      @(posedge clk); #1;
      ib.wbm_cyc_i = '0; ib.wbm_stb_i = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
